sha_uart_sequencer: RTL and testbench
=====================================

// Module: sha_uart_sequencer
// PURPOSE
//  Sequences the SHA-256 hash top for the UART link. Collects a fixed-length message frame from the
//  UART receiver byte by byte and launches one hash. When the hash completes, it streams the 32 digest
//  bytes to the UART transmitter, most significant byte first. Sits between the uart_rx/uart_tx pair and
//  the hash top, which needs a stable raw message and a one-cycle start pulse.
// PARAMETERS
//  MSG_BYTES    56          frame length in bytes; sha_msg width = MSG_BYTES*8 (matches hash INPUT_WIDTH 448)
//  TIMEOUT_CYC  1_000_000   inter-byte idle limit in clk cycles (used only with SHA_SEQ_TIMEOUT_EN)
// PORTS
//  clk           in   1            system clock
//  reset         in   1            asynchronous, active-high reset
//  rx_data       in   8            received byte
//  rx_valid      in   1            one-cycle strobe: rx_data valid
//  tx_data       out  8            byte to transmit
//  tx_start      out  1            one-cycle strobe: launch tx_data
//  tx_busy       in   1            transmitter busy; rises the cycle after tx_start, falls when byte is sent
//  sha_start     out  1            one-cycle start pulse to hash top
//  sha_msg       out  MSG_BYTES*8  message to hash; first received byte in bits [MSG_BYTES*8-1 -: 8]
//  sha_hash      in   256          digest from hash top; sampled when sha_complete=1
//  sha_complete  in   1            hash done strobe
//  busy          out  1            high in every state except COLLECT
//  rx_overrun    out  1            one-cycle pulse: byte received while busy, byte dropped
//  frame_abort   out  1            one-cycle pulse: partial frame discarded on timeout
// BEHAVIOUR
//  Reset (async): state=COLLECT, byte_cnt=0, sha_msg=0, tx_data=0, all strobes 0, busy=0.
//  Reset takes effect mid-frame, mid-hash and mid-send; nothing is resumed after reset.
//  States:
//  - COLLECT: on rx_valid, shift rx_data into sha_msg LSB end (sha_msg <= {sha_msg[..-8], rx_data});
//    byte_cnt++. When byte MSG_BYTES-1 (counting from 0) is accepted -> LAUNCH.
//  - LAUNCH: sha_start=1 for exactly one cycle -> WAIT_HASH. sha_start rises 1 cycle after the last byte strobe.
//  - WAIT_HASH: hold sha_msg stable. On sha_complete, latch sha_hash into digest reg; idx=0 -> SEND.
//  - SEND: when tx_busy=0, drive tx_data=digest[255-8*idx -: 8] and tx_start=1 for one cycle -> ACK.
//  - ACK: wait for tx_busy=1 -> DRAIN.
//  - DRAIN: wait for tx_busy=0. If idx=31: byte_cnt=0 -> COLLECT. Otherwise idx++ -> SEND.
//  Boundary conditions:
//  - rx_valid in any state except COLLECT: byte dropped; rx_overrun pulses in the same cycle.
//  - sha_complete outside WAIT_HASH: ignored.
//  - rx_valid on the cycle DRAIN returns to COLLECT: dropped with rx_overrun (state still busy).
//  - byte_cnt counts 0..MSG_BYTES-1 and never wraps while in COLLECT.
//  - sha_msg keeps the old frame until the first new byte shifts in.
//  Turnaround: sha_complete -> first tx_start = 2 cycles (WAIT_HASH->SEND->strobe registered).
// CONFIGURATION
//  SHA_SEQ_TIMEOUT_EN defined: 32-bit idle counter runs in COLLECT while byte_cnt != 0 and resets on
//  each rx_valid. When it reaches TIMEOUT_CYC-1: byte_cnt=0, frame_abort pulses 1 cycle, sha_msg unchanged.
//  SHA_SEQ_TIMEOUT_EN undefined: no counter; frame_abort tied 0; a partial frame waits indefinitely.
// STRUCTURE
//  Package sha_uart_pkg holds:
//  - state encoding localparams: COLLECT, LAUNCH, WAIT_HASH, SEND, ACK, DRAIN (3 bits)
//  - DIGEST_BYTES=32, BYTE_W=8
//  Sub-module sha_digest_serializer owns SEND/ACK/DRAIN, idx and the digest register:
//  - inputs: load, digest
//  - outputs: tx_data, tx_start, done
//  Parent owns collect, launch and overrun/timeout logic.
// TESTING
//  1 Send 56 bytes 0x00..0x37 -> sha_start pulses once, 1 cycle after byte 55; sha_msg=448'h0001..37.
//  2 Stub hash returns 256'h000102..1F with sha_complete -> tx bytes 0x00,0x01,..,0x1F in order,
//    32 tx_start pulses, then busy=0.
//  3 Byte arrives during WAIT_HASH -> rx_overrun pulse, byte dropped; next frame of 56 bytes hashes correctly.
//  4 Assert reset during SEND at idx=10 -> all outputs zero at once.
//    A following full frame plus hash yields all 32 bytes, starting from 0x00.
//  5 (SHA_SEQ_TIMEOUT_EN, TIMEOUT_CYC=100) Send 20 bytes, idle 100 cycles -> frame_abort pulse.
//    Then 56 bytes -> sha_msg holds only the new bytes.
//  6 Hold tx_busy high 50 cycles per byte -> exactly one tx_start per byte; no start while tx_busy=1.

Source files
------------

// File: rtl/sha_uart_sequencer_pkg.sv
// Shared types and constants for the SHA-256 / UART sequencer.
package sha_uart_pkg;

    localparam int DIGEST_BYTES = 32;
    localparam int BYTE_W       = 8;

    // Top-level sequencing states. SEND, ACK and DRAIN are stepped by the
    // digest serializer; the parent parks in SEND while the serializer runs.
    typedef enum logic [2:0] {
        COLLECT   = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_HASH = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        DRAIN     = 3'd5
    } seq_state_t;

endpackage

// File: rtl/sha_uart_sequencer_if.sv
// UART and hash-top signal bundle for the sequencer.
// master = sequencer side, slave = UART pair / hash top side.
interface sha_uart_sequencer_if #(
    parameter int MSG_BYTES = 56
);
    logic [7:0]             rx_data;
    logic                   rx_valid;
    logic [7:0]             tx_data;
    logic                   tx_start;
    logic                   tx_busy;
    logic                   sha_start;
    logic [MSG_BYTES*8-1:0] sha_msg;
    logic [255:0]           sha_hash;
    logic                   sha_complete;
    logic                   busy;
    logic                   rx_overrun;
    logic                   frame_abort;

    modport master (
        input  rx_data, rx_valid, tx_busy, sha_hash, sha_complete,
        output tx_data, tx_start, sha_start, sha_msg, busy, rx_overrun, frame_abort
    );

    modport slave (
        output rx_data, rx_valid, tx_busy, sha_hash, sha_complete,
        input  tx_data, tx_start, sha_start, sha_msg, busy, rx_overrun, frame_abort
    );
endinterface

// File: rtl/sha_uart_sequencer_serializer.sv
// Streams a latched 256-bit digest to the UART transmitter, MSB byte first,
// handshaking each byte through tx_busy (SEND -> ACK -> DRAIN).
module sha_digest_serializer
    import sha_uart_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [255:0] digest,
    input  logic         tx_busy,
    output logic [7:0]   tx_data,
    output logic         tx_start,
    output logic         done
);

    seq_state_t   st, st_nxt;
    logic         active, active_nxt;
    logic         start_nxt, idx_inc;
    logic [4:0]   idx;
    logic [255:0] digest_q;
    logic [7:0]   cur_byte;

    assign cur_byte = digest_q[BYTE_W*(DIGEST_BYTES-1-int'(idx)) +: BYTE_W];

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st     <= SEND;
            active <= 1'b0;
        end else begin
            st     <= st_nxt;
            active <= active_nxt;
        end
    end

    // Next-state: one registered tx_start per byte, then wait for the
    // transmitter to take it (busy high) and finish it (busy low).
    always_comb begin
        st_nxt     = st;
        active_nxt = active;
        start_nxt  = 1'b0;
        idx_inc    = 1'b0;
        done       = 1'b0;
        if (load) begin
            active_nxt = 1'b1;
            st_nxt     = SEND;
        end else if (active) begin
            case (st)
                SEND: if (!tx_busy) begin
                    start_nxt = 1'b1;
                    st_nxt    = ACK;
                end
                ACK: if (tx_busy) st_nxt = DRAIN;
                DRAIN: if (!tx_busy) begin
                    st_nxt = SEND;
                    if (idx == 5'(DIGEST_BYTES-1)) begin
                        done       = 1'b1;
                        active_nxt = 1'b0;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
                default: st_nxt = SEND;
            endcase
        end
    end

    // Digest latch, byte index and registered transmit strobe/data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digest_q <= '0;
            idx      <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_start <= start_nxt;
            if (load) begin
                digest_q <= digest;
                idx      <= '0;
            end else if (idx_inc) begin
                idx <= idx + 5'd1;
            end
            if (start_nxt) tx_data <= cur_byte;
        end
    end

endmodule

// File: rtl/sha_uart_sequencer.sv
// Collects a MSG_BYTES frame from the UART receiver, launches one hash and
// hands the digest to the serializer for transmission.
// Optional: define SHA_SEQ_TIMEOUT_EN to discard partial frames after
// TIMEOUT_CYC idle cycles.
module sha_uart_sequencer
    import sha_uart_pkg::*;
#(
    parameter int MSG_BYTES   = 56,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    sha_uart_sequencer_if.master bus
);

    localparam int MSG_W = MSG_BYTES * BYTE_W;
    localparam int CNT_W = $clog2(MSG_BYTES);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(MSG_BYTES - 1);

    seq_state_t       state, state_nxt;
    logic [CNT_W-1:0] byte_cnt;
    logic [MSG_W-1:0] msg_q;
    logic             accept, ser_load, ser_done, clr_cnt, abort;

    sha_digest_serializer u_ser (
        .clk      (clk),
        .reset    (reset),
        .load     (ser_load),
        .digest   (bus.sha_hash),
        .tx_busy  (bus.tx_busy),
        .tx_data  (bus.tx_data),
        .tx_start (bus.tx_start),
        .done     (ser_done)
    );

    assign bus.sha_msg     = msg_q;
    assign bus.busy        = (state != COLLECT);
    assign bus.sha_start   = (state == LAUNCH);
    assign bus.rx_overrun  = bus.rx_valid && (state != COLLECT);
    assign bus.frame_abort = abort;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= COLLECT;
        else       state <= state_nxt;
    end

    // Next-state: collect -> one-cycle launch -> wait for digest -> serialize.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        ser_load  = 1'b0;
        clr_cnt   = 1'b0;
        case (state)
            COLLECT: if (bus.rx_valid) begin
                accept = 1'b1;
                if (byte_cnt == LAST_BYTE) state_nxt = LAUNCH;
            end
            LAUNCH:    state_nxt = WAIT_HASH;
            WAIT_HASH: if (bus.sha_complete) begin
                ser_load  = 1'b1;
                state_nxt = SEND;
            end
            SEND: if (ser_done) begin
                clr_cnt   = 1'b1;
                state_nxt = COLLECT;
            end
            default: state_nxt = COLLECT;
        endcase
    end

    // Byte counter and message shift register; the old frame stays visible
    // until the first byte of the next frame shifts in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt <= '0;
            msg_q    <= '0;
        end else begin
            if (clr_cnt || abort)                       byte_cnt <= '0;
            else if (accept && byte_cnt != LAST_BYTE)   byte_cnt <= byte_cnt + 1'b1;
            if (accept) msg_q <= {msg_q[MSG_W-BYTE_W-1:0], bus.rx_data};
        end
    end

`ifdef SHA_SEQ_TIMEOUT_EN
    localparam logic [31:0] IDLE_LIMIT = 32'(TIMEOUT_CYC - 1);
    logic [31:0] idle_cnt;

    assign abort = (state == COLLECT) && (byte_cnt != '0) && !bus.rx_valid
                   && (idle_cnt == IDLE_LIMIT);

    // Inter-byte idle counter, armed only while a partial frame is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            idle_cnt <= '0;
        else if (state != COLLECT || byte_cnt == '0 || bus.rx_valid || abort)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + 32'd1;
    end
`else
    assign abort = 1'b0;
`endif

endmodule

// File: tb/tb_sha_uart_sequencer.sv
// Scoreboard bench for sha_uart_sequencer: stimulus pushes expected tx bytes
// and messages, a negedge monitor pops and compares them.
module tb_sha_uart_sequencer;
    localparam int MSG_BYTES = 56;
    localparam int MSG_W     = MSG_BYTES * 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sha_uart_sequencer_if #(.MSG_BYTES(MSG_BYTES)) bus ();

    sha_uart_sequencer #(.MSG_BYTES(MSG_BYTES), .TIMEOUT_CYC(100)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0, errors = 0;
    int tx_cnt = 0, sha_cnt = 0, ovr_cnt = 0, abort_cnt = 0;
    int busy_len = 3;
    logic [7:0]       exp_tx_q[$];
    logic [MSG_W-1:0] exp_msg_q[$];
    logic [255:0]     hash_a, hash_b;

    task automatic check(input string name, input logic [MSG_W-1:0] act, input logic [MSG_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    // Monitor: compares every transmitted byte and every hash launch.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.tx_start) begin
                tx_cnt++;
                check("tx_start_while_busy", bus.tx_busy, 1'b0);
                if (exp_tx_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tx_unexpected: got byte %0h with empty queue", bus.tx_data);
                end else begin
                    check("tx_byte", bus.tx_data, exp_tx_q.pop_front());
                end
            end
            if (bus.sha_start) begin
                sha_cnt++;
                if (exp_msg_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sha_start_unexpected: got msg %0h", bus.sha_msg);
                end else begin
                    check("sha_msg", bus.sha_msg, exp_msg_q.pop_front());
                end
            end
            if (bus.rx_overrun)  ovr_cnt++;
            if (bus.frame_abort) abort_cnt++;
        end
    end

    // UART transmitter model: busy rises the cycle after tx_start.
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_start && !reset) begin
                @(posedge clk); #1 bus.tx_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 bus.tx_busy = 1'b0;
            end
        end
    end

    function automatic logic [MSG_W-1:0] frame_msg(input logic [7:0] base);
        logic [MSG_W-1:0] m = '0;
        for (int i = 0; i < MSG_BYTES; i++) m = (m << 8) | MSG_W'(8'(base + i));
        return m;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    // Sends a full frame; returns in the cycle the launch strobe must be high.
    task automatic send_frame(input logic [7:0] base);
        exp_msg_q.push_back(frame_msg(base));
        for (int i = 0; i < MSG_BYTES; i++) send_byte(8'(base + i));
        check("sha_start_latency", bus.sha_start, 1'b1);
        check("busy_in_launch", bus.busy, 1'b1);
    endtask

    // Called in WAIT_HASH; delivers a digest and checks the 2-cycle turnaround.
    task automatic hash_and_check(input logic [255:0] h);
        for (int i = 0; i < 32; i++) exp_tx_q.push_back(8'((h >> (8 * (31 - i))) & 256'hFF));
        bus.sha_hash     = h;
        bus.sha_complete = 1'b1;
        @(posedge clk); #1;
        bus.sha_complete = 1'b0;
        check("turnaround_early", bus.tx_start, 1'b0);
        @(posedge clk); #1;
        check("turnaround", bus.tx_start, 1'b1);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (bus.busy && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check("return_idle", bus.busy, 1'b0);
        check("tx_queue_drained", exp_tx_q.size(), 0);
    endtask

    task automatic wait_txcnt(input int target);
        int n = 0;
        while (tx_cnt < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (tx_cnt < target) timeout_fail("wait_tx_count");
    endtask

    task automatic wait_busy_level(input logic lvl);
        int n = 0;
        while (bus.tx_busy !== lvl && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (bus.tx_busy !== lvl) timeout_fail("wait_tx_busy");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        bus.rx_data      = '0;
        bus.rx_valid     = 1'b0;
        bus.sha_hash     = '0;
        bus.sha_complete = 1'b0;
        hash_a = '0;
        hash_b = '0;
        for (int i = 0; i < 32; i++) begin
            hash_a = (hash_a << 8) | 256'(i);
            hash_b = (hash_b << 8) | 256'(8'hA5 ^ 8'(i));
        end

        // Reset state
        @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_tx_start", bus.tx_start, 1'b0);
        check("rst_tx_data", bus.tx_data, 8'h00);
        check("rst_sha_start", bus.sha_start, 1'b0);
        check("rst_sha_msg", bus.sha_msg, '0);
        check("rst_frame_abort", bus.frame_abort, 1'b0);
        @(posedge clk); #1 reset = 1'b0;

        // sha_complete while collecting is ignored
        bus.sha_hash = hash_b;
        bus.sha_complete = 1'b1;
        @(posedge clk); #1 bus.sha_complete = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("stray_complete_busy", bus.busy, 1'b0);
        check("stray_complete_no_tx", tx_cnt, 0);

        // Frame 0x00..0x37, digest 00..1F, byte arriving as DRAIN returns is dropped
        send_frame(8'h00);
        @(posedge clk); #1;
        t0 = tx_cnt;
        hash_and_check(hash_a);
        wait_txcnt(t0 + 32);
        wait_busy_level(1'b1);
        wait_busy_level(1'b0);
        bus.rx_data  = 8'h77;
        bus.rx_valid = 1'b1;
        #1 check("overrun_at_return", bus.rx_overrun, 1'b1);
        check("busy_at_return", bus.busy, 1'b1);
        @(posedge clk); #1 bus.rx_valid = 1'b0;
        check("idle_after_send", bus.busy, 1'b0);
        check("msg_after_drop", bus.sha_msg, frame_msg(8'h00));
        check("tx_count_frame1", tx_cnt - t0, 32);

        // Byte during WAIT_HASH is dropped
        send_frame(8'h80);
        @(posedge clk); #1;
        bus.rx_data  = 8'h99;
        bus.rx_valid = 1'b1;
        #1 check("overrun_wait_hash", bus.rx_overrun, 1'b1);
        @(posedge clk); #1 bus.rx_valid = 1'b0;
        check("msg_hold_wait_hash", bus.sha_msg, frame_msg(8'h80));
        hash_and_check(hash_b);
        wait_idle(2000);
        send_frame(8'h40);
        @(posedge clk); #1;
        hash_and_check(hash_a);
        wait_idle(2000);

        // Reset mid-send at idx 10, then a clean frame
        t0 = tx_cnt;
        send_frame(8'h10);
        @(posedge clk); #1;
        hash_and_check(hash_a);
        wait_txcnt(t0 + 10);
        wait_busy_level(1'b1);
        wait_busy_level(1'b0);
        @(posedge clk); #1 reset = 1'b1;
        #1;
        check("midsend_rst_busy", bus.busy, 1'b0);
        check("midsend_rst_tx_start", bus.tx_start, 1'b0);
        check("midsend_rst_tx_data", bus.tx_data, 8'h00);
        check("midsend_rst_sha_msg", bus.sha_msg, '0);
        check("midsend_rst_tx_sent", tx_cnt - t0, 10);
        exp_tx_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        send_frame(8'h00);
        @(posedge clk); #1;
        hash_and_check(hash_a);
        wait_idle(2000);

`ifdef SHA_SEQ_TIMEOUT_EN
        // Partial frame abandoned after the idle limit
        for (int i = 0; i < 20; i++) send_byte(8'hE0 + 8'(i));
        repeat (110) @(posedge clk);
        #1 check("frame_abort_count", abort_cnt, 1);
        send_frame(8'h60);
        @(posedge clk); #1;
        hash_and_check(hash_b);
        wait_idle(2000);
`endif

        // Slow transmitter: one start per byte, never while busy
        busy_len = 50;
        t0 = tx_cnt;
        send_frame(8'h20);
        @(posedge clk); #1;
        hash_and_check(hash_b);
        wait_idle(4000);
        check("slow_tx_count", tx_cnt - t0, 32);

`ifdef SHA_SEQ_TIMEOUT_EN
        check("sha_start_total", sha_cnt, 7);
`else
        check("sha_start_total", sha_cnt, 6);
        check("frame_abort_total", abort_cnt, 0);
`endif
        check("overrun_total", ovr_cnt, 2);
        check("msg_queue_drained", exp_msg_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
